// File: rtl/alu_operand_stager_pkg.sv
// Shared types for the operand stager: state encoding and operand width.
package alu_operand_stager_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GOT_A   = 2'd1,
    PRESENT = 2'd2
  } state_e;

  function automatic logic handshake(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/alu_operand_stager_if.sv
// Narrow operand input stream plus the assembled A/B pair toward the logic unit.
interface alu_operand_stager_if
  import alu_operand_stager_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             op_valid;
  logic             op_ready;

  modport master (
    output in_data, in_valid, op_ready,
    input  in_ready, opA, opB, op_valid
  );

  modport slave (
    input  in_data, in_valid, op_ready,
    output in_ready, opA, opB, op_valid
  );
endinterface

// File: rtl/alu_operand_stager.sv
// Collects A then B from a single narrow bus and presents them as one pair,
// holding the pair under backpressure and counting consumed pairs.
module alu_operand_stager
  import alu_operand_stager_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  alu_operand_stager_if.slave  bus,
  output logic [CNT_W-1:0]     pair_count
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  opa_q, opb_q;
  logic [CNT_W-1:0]  count_q;
  logic              in_ready_c;
  logic              load_a, load_b, consume;

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    load_a     = 1'b0;
    load_b     = 1'b0;
    consume    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          load_a  = 1'b1;
          state_d = GOT_A;
        end
      end
      GOT_A: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          load_b  = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        // A new A word may enter in the same cycle the held pair leaves.
        in_ready_c = bus.op_ready;
        if (bus.op_ready) begin
          consume = 1'b1;
          if (bus.in_valid) begin
            load_a  = 1'b1;
            state_d = GOT_A;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush overrides everything: nothing accepted, nothing counted.
    if (flush) begin
      in_ready_c = 1'b0;
      load_a     = 1'b0;
      load_b     = 1'b0;
      consume    = 1'b0;
      state_d    = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q <= '0;
      opb_q <= '0;
    end else begin
      if (load_a) opa_q <= bus.in_data;
      if (load_b) opb_q <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          count_q <= '0;
    else if (consume) count_q <= count_q + CNT_W'(1);
  end

  assign bus.in_ready = in_ready_c;
  assign bus.opA      = opa_q;
  assign bus.opB      = opb_q;
  assign bus.op_valid = (state_q == PRESENT);
  assign pair_count   = count_q;

  logic unused_hs;
  assign unused_hs = handshake(1'b0, 1'b0);

endmodule

// File: tb/tb_alu_operand_stager.sv
// Bench for alu_operand_stager: vector table of pairs plus hand-written overlap,
// flush and reset sequences; a negedge monitor scoreboards every presented pair.
module tb_alu_operand_stager;

  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [CW-1:0] pair_count;

  alu_operand_stager_if #(.WIDTH(4)) bus ();

  alu_operand_stager #(.WIDTH(4), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .pair_count (pair_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  logic [7:0] sb[$];
  int exp_cnt = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         stall;
    int         cnt;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pairs leave either by consume (checked) or by flush (dropped).
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_cnt = 0;
    end else begin
      chk("pair_count_track", int'(pair_count), exp_cnt);
      if (bus.op_valid && (flush || bus.op_ready)) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_pair", 1, 0);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          if (!flush) begin
            chk("opA", int'(bus.opA), int'(e[7:4]));
            chk("opB", int'(bus.opB), int'(e[3:0]));
            exp_cnt = (exp_cnt + 1) % 4;
          end
        end
      end
    end
  end

  task automatic put_word(input logic [3:0] w, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_pair(input logic [3:0] a, input logic [3:0] b);
    int w;
    put_word(a, w);
    put_word(b, w);
    sb.push_back({a, b});
  endtask

  task automatic wait_consume();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.op_valid && bus.op_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    chk("consume_seen", int'(ok), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    tbl[0] = '{4'b0101, 4'b1010, 0, 1};
    tbl[1] = '{4'b1100, 4'b1110, 5, 2};
    tbl[2] = '{4'b0011, 4'b1001, 2, 3};
    tbl[3] = '{4'b1111, 4'b0000, 0, 0};
    tbl[4] = '{4'b0110, 4'b0110, 1, 1};

    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 4'h0; bus.op_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op_valid", int'(bus.op_valid), 0);
    chk("rst_opA", int'(bus.opA), 0);
    chk("rst_opB", int'(bus.opB), 0);
    chk("rst_count", int'(pair_count), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;

    // Vector table: basic pairs, backpressure, and counter wrap with CNT_W=2.
    for (int k = 0; k < 5; k++) begin
      bus.op_ready = (tbl[k].stall == 0);
      send_pair(tbl[k].a, tbl[k].b);
      for (int s = 0; s < tbl[k].stall; s++) begin
        bus.in_valid = 1'b1;
        bus.in_data  = ~tbl[k].a;
        @(negedge clk);
        chk("hold_opA", int'(bus.opA), int'(tbl[k].a));
        chk("hold_opB", int'(bus.opB), int'(tbl[k].b));
        chk("hold_op_valid", int'(bus.op_valid), 1);
        chk("hold_in_ready", int'(bus.in_ready), 0);
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.op_ready = 1'b1;
      wait_consume();
      chk("vec_count", int'(pair_count), tbl[k].cnt);
      chk("vec_op_valid_drop", int'(bus.op_valid), 0);
    end

    // Overlap: next A accepted in the same cycle the pair is consumed.
    send_pair(4'b1010, 4'b0101);
    put_word(4'b1111, w);
    chk("overlap_wait", w, 0);
    @(negedge clk);
    chk("overlap_op_valid", int'(bus.op_valid), 0);
    chk("overlap_opA", int'(bus.opA), 4'b1111);
    chk("overlap_in_ready", int'(bus.in_ready), 1);
    chk("overlap_count", int'(pair_count), 2);
    @(posedge clk); #1;
    put_word(4'b0000, w);
    sb.push_back({4'b1111, 4'b0000});
    chk("overlap_b_wait", w, 0);
    wait_consume();
    chk("overlap_count2", int'(pair_count), 3);

    // Flush after A: partial word must never be presented.
    put_word(4'b0101, w);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b0110;
    @(negedge clk);
    chk("flush_in_ready", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_op_valid", int'(bus.op_valid), 0);
    @(posedge clk); #1;
    send_pair(4'b1111, 4'b1111);
    wait_consume();
    chk("flush_pair_count", int'(pair_count), 0);

    // Flush while presenting with op_ready high: pair dropped, count unchanged.
    send_pair(4'b0001, 4'b0010);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flushp_op_valid", int'(bus.op_valid), 0);
    chk("flushp_count", int'(pair_count), 0);
    chk("flushp_opA_kept", int'(bus.opA), 4'b0001);
    chk("flushp_opB_kept", int'(bus.opB), 4'b0010);
    @(posedge clk); #1;

    // Asynchronous reset mid-sim while a pair is held.
    send_pair(4'b1000, 4'b0001);
    wait_consume();
    chk("pre_rst_count", int'(pair_count), 1);
    bus.op_ready = 1'b0;
    send_pair(4'b1001, 4'b0110);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_op_valid", int'(bus.op_valid), 0);
    chk("arst_opA", int'(bus.opA), 0);
    chk("arst_opB", int'(bus.opB), 0);
    chk("arst_count", int'(pair_count), 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(bus.in_ready), 1);
    chk("post_rst_op_valid", int'(bus.op_valid), 0);
    @(posedge clk); #1;
    bus.op_ready = 1'b1;
    send_pair(4'b0111, 4'b1000);
    wait_consume();
    chk("post_rst_count", int'(pair_count), 1);

    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
